rf_writeback_unit: RTL

//  Write-side master of the 16-bit CPU register file. Merges ALU and load results into one in-order write queue.

---
 rtl/rf_pkg.sv | 19 +
 rtl/wb_queue.sv | 62 ++++++
 rtl/rf_writeback_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and constants, used by the write-back unit
// and by register-file consumers.
package rf_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 8;
   localparam int WB_DEPTH = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
      return int'(addr) < NUM_REGS;
   endfunction

endpackage

// File: rtl/wb_queue.sv
// Write-back queue: 2-push / 1-pop circular buffer of wb_entry_t.
// When empty, an incoming push is presented on the pop side in the same cycle.
module wb_queue
   import rf_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic                            i_push_a,
   input  wb_entry_t                       i_entry_a,
   input  logic                            i_push_b,
   input  wb_entry_t                       i_entry_b,
   output logic                            o_out_valid,
   output wb_entry_t                       o_out_entry,
   output logic [$clog2(DEPTH):0]          o_count,
   output logic [$clog2(DEPTH)-1:0]        o_head,
   output wb_entry_t [DEPTH-1:0]           o_mem
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t [DEPTH-1:0] r_mem;
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_W-1:0]      r_count;
   logic [CNT_W-1:0]      w_npush;
   wb_entry_t             w_first;

   assign w_npush = CNT_W'(i_push_a) + CNT_W'(i_push_b);
   assign w_first = i_push_a ? i_entry_a : i_entry_b;

   // Every push is stored at the tail even when it is consumed directly;
   // head advances with it, so tail - head always equals count.
   assign o_out_valid = (r_count != '0) || i_push_a || i_push_b;
   assign o_out_entry = (r_count != '0) ? r_mem[r_head] : w_first;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_mem   <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push_a && i_push_b) begin
            r_mem[r_tail]              <= i_entry_a;
            r_mem[r_tail + PTR_W'(1)]  <= i_entry_b;
         end else if (i_push_a || i_push_b) begin
            r_mem[r_tail] <= w_first;
         end
         r_tail  <= r_tail + w_npush[PTR_W-1:0];
         r_head  <= r_head + PTR_W'(o_out_valid);
         r_count <= r_count + w_npush - CNT_W'(o_out_valid);
      end
   end

   assign o_count = r_count;
   assign o_head  = r_head;
   assign o_mem   = r_mem;

endmodule

// File: rtl/rf_writeback_unit.sv
// Register-file write-back master: merges load and ALU results in order and
// drains one write per cycle to WE3/A3/WD3. Decode bypass exists only when RF_WB_BYPASS_EN is defined.
module rf_writeback_unit
   import rf_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              stall,
   output logic              WE3,
   output logic [ADDR_W-1:0] A3,
   output logic [DATA_W-1:0] WD3,
   output logic              err_addr,
   input  logic [ADDR_W-1:0] byp_a1,
   input  logic [ADDR_W-1:0] byp_a2,
   output logic              byp_hit1,
   output logic              byp_hit2,
   output logic [DATA_W-1:0] byp_d1,
   output logic [DATA_W-1:0] byp_d2
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic                  w_ld_fire;
   logic                  w_alu_acc;
   logic                  w_push_a;
   logic                  w_push_b;
   logic                  w_out_valid;
   wb_entry_t             w_out_entry;
   logic [CNT_W-1:0]      w_count;
   logic [PTR_W-1:0]      w_head;
   wb_entry_t [DEPTH-1:0] w_mem;
   logic [CNT_W-1:0]      w_free;

   logic                  r_we3;
   logic [ADDR_W-1:0]     r_a3;
   logic [DATA_W-1:0]     r_wd3;
   logic                  r_err;

   // Free space counts the slot released by this cycle's pop.
   assign w_free   = CNT_W'(DEPTH) - w_count + CNT_W'(w_count != '0);
   assign stall    = w_free < CNT_W'(2);
   assign ld_ready = (w_free >= CNT_W'(1)) && !stall;

   assign w_ld_fire = ld_valid && ld_ready;
   assign w_alu_acc = alu_valid && !stall;
   assign w_push_a  = w_ld_fire && addr_legal(ld_addr);
   assign w_push_b  = w_alu_acc && addr_legal(alu_addr);

   wb_queue #(.DEPTH(DEPTH)) u_queue (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .i_push_a    (w_push_a),
      .i_entry_a   ('{addr: ld_addr, data: ld_data}),
      .i_push_b    (w_push_b),
      .i_entry_b   ('{addr: alu_addr, data: alu_data}),
      .o_out_valid (w_out_valid),
      .o_out_entry (w_out_entry),
      .o_count     (w_count),
      .o_head      (w_head),
      .o_mem       (w_mem)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_we3 <= 1'b0;
         r_a3  <= '0;
         r_wd3 <= '0;
         r_err <= 1'b0;
      end else begin
         r_we3 <= w_out_valid;
         if (w_out_valid) begin
            r_a3  <= w_out_entry.addr;
            r_wd3 <= w_out_entry.data;
         end
         r_err <= (w_ld_fire && !addr_legal(ld_addr)) ||
                  (w_alu_acc && !addr_legal(alu_addr));
      end
   end

   assign WE3      = r_we3;
   assign A3       = r_a3;
   assign WD3      = r_wd3;
   assign err_addr = r_err;

`ifdef RF_WB_BYPASS_EN
   // Scan from oldest to youngest so the tail-most match wins; in-flight is oldest.
   function automatic logic [DATA_W:0] f_lookup(
      input logic [ADDR_W-1:0]     a,
      input logic                  fl_we,
      input logic [ADDR_W-1:0]     fl_addr,
      input logic [DATA_W-1:0]     fl_data,
      input wb_entry_t [DEPTH-1:0] mem,
      input logic [PTR_W-1:0]      head,
      input logic [CNT_W-1:0]      count
   );
      logic [DATA_W:0]  res;
      logic [PTR_W-1:0] idx;
      res = '0;
      if (fl_we && fl_addr == a) res = {1'b1, fl_data};
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (CNT_W'(i) < count && mem[idx].addr == a) res = {1'b1, mem[idx].data};
      end
      return res;
   endfunction

   assign {byp_hit1, byp_d1} = f_lookup(byp_a1, r_we3, r_a3, r_wd3, w_mem, w_head, w_count);
   assign {byp_hit2, byp_d2} = f_lookup(byp_a2, r_we3, r_a3, r_wd3, w_mem, w_head, w_count);
`else
   logic w_unused_byp;
   assign w_unused_byp = ^{byp_a1, byp_a2, w_head, w_mem};
   assign byp_hit1 = 1'b0;
   assign byp_hit2 = 1'b0;
   assign byp_d1   = '0;
   assign byp_d2   = '0;
`endif

   a_alu_no_stall : assert property (@(posedge CLK) disable iff (!RST_N) !(alu_valid && stall));

endmodule
